// File: rtl/i2c_slave.sv
// ----------------------------------------------------------------------------
// i2c_slave
//
// I2C target controller and the responding end for the team's i2c_master.
// SCL/SDA are oversampled in the sysclk domain. The block detects START,
// STOP and repeated START. It answers one fixed 7-bit address, ACKs the
// address and every written byte, and hands written bytes to local logic.
// On a read it fetches bytes from local logic and shifts them out MSB first.
//
// Optional build macro: CLOCK_STRETCH_EN
//    When defined, the block holds SCL low at the point a read byte must be
//    latched if tx_valid is low, and releases SCL once the byte is taken.
//    When undefined, scl_oe is tied low, tx_valid is ignored and tx_data is
//    latched unconditionally.
//
// Parameters:
//    ADDRESS     7-bit target address (default 7'h42)
//    SYNC_STAGES synchronizer depth on scl_i/sda_i, must be at least 2
//
// Ports:
//    sysclk    in   system clock
//    reset_n   in   asynchronous active-low reset
//    scl_i     in   SCL pad level
//    sda_i     in   SDA pad level
//    scl_oe    out  1 = pull SCL low (clock stretch); never drives high
//    sda_oe    out  1 = pull SDA low; never drives high
//    rx_data   out  last byte written by the master, held until the next one
//    rx_valid  out  one-cycle pulse when rx_data updates
//    tx_data   in   next byte to return on a read
//    tx_valid  in   tx_data is ready (stretch build only)
//    tx_req    out  one-cycle pulse asking for the next read byte
//    busy      out  high from address match until STOP or repeated START
// ----------------------------------------------------------------------------
module i2c_slave #(
   parameter logic [6:0] ADDRESS     = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_req,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WRITE_BYTE,
      ST_WRITE_ACK,
      ST_READ_BYTE,
      ST_READ_ACK,
      ST_WAIT_STOP
   } state_t;

   // Synchronizer chains plus one history flop per pin for edge detection
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_hist;
   logic                   sda_hist;
   logic                   scl_s;
   logic                   sda_s;

   // Bus events decoded from the synchronized levels
   logic stop_evt;
   logic start_evt;
   logic scl_rise;
   logic scl_fall;

   // Local data-ready qualifier for the read latch points
   logic tx_ready;

   // Registered state and its next-state values
   state_t     state, state_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [6:0] shift_q, shift_q_nx;
   logic [6:0] tx_shift, tx_shift_nx;
   logic       rw_bit, rw_nx;
   logic       byte_done, byte_done_nx;
   logic       busy_q, busy_nx;
   logic       sda_oe_q, sda_oe_nx;
   logic       scl_hold, scl_hold_nx;
   logic [7:0] rx_data_q, rx_data_nx;
   logic       rx_valid_q, rx_valid_nx;
   logic       tx_req_q, tx_req_nx;

   // Working values inside the next-state logic
   logic [7:0] shift_full;
   logic       latch_tx;

   // Pins enter the synchronizers; both chains preset to 1 so the bus
   // looks idle straight out of reset and no false event is decoded.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_hist <= scl_sync[SYNC_STAGES-1];
         sda_hist <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   assign stop_evt  = scl_s & sda_s & ~sda_hist;
   assign start_evt = scl_s & ~sda_s & sda_hist;
   assign scl_rise  = scl_s & ~scl_hist;
   assign scl_fall  = ~scl_s & scl_hist;

`ifdef CLOCK_STRETCH_EN
   assign tx_ready = tx_valid;
   assign scl_oe   = scl_hold;
`else
   logic unused_tx_valid;
   assign tx_ready        = 1'b1;
   assign scl_oe          = 1'b0;
   assign unused_tx_valid = tx_valid;
`endif

   // State register for the protocol FSM and every datapath register it
   // owns; everything is cleared so the bus is released at once on reset.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         shift_q    <= 7'd0;
         tx_shift   <= 7'd0;
         rw_bit     <= 1'b0;
         byte_done  <= 1'b0;
         busy_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         scl_hold   <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         shift_q    <= shift_q_nx;
         tx_shift   <= tx_shift_nx;
         rw_bit     <= rw_nx;
         byte_done  <= byte_done_nx;
         busy_q     <= busy_nx;
         sda_oe_q   <= sda_oe_nx;
         scl_hold   <= scl_hold_nx;
         rx_data_q  <= rx_data_nx;
         rx_valid_q <= rx_valid_nx;
         tx_req_q   <= tx_req_nx;
      end
   end

   // Next-state logic. STOP beats START beats SCL edges. byte_done marks
   // that eight bits have been taken, so the SCL fall straight after a
   // START (bit counter also 0) is not mistaken for the end of a byte.
   // latch_tx flags the points where a read byte must be loaded; when local
   // data is not ready the stretch build holds SCL and retries every cycle.
   always_comb begin
      state_nx     = state;
      bit_cnt_nx   = bit_cnt;
      shift_q_nx   = shift_q;
      tx_shift_nx  = tx_shift;
      rw_nx        = rw_bit;
      byte_done_nx = byte_done;
      busy_nx      = busy_q;
      sda_oe_nx    = sda_oe_q;
      scl_hold_nx  = scl_hold;
      rx_data_nx   = rx_data_q;
      rx_valid_nx  = 1'b0;
      tx_req_nx    = 1'b0;
      latch_tx     = 1'b0;
      shift_full   = {shift_q, sda_s};

      if (stop_evt) begin
         state_nx     = ST_IDLE;
         bit_cnt_nx   = 3'd0;
         byte_done_nx = 1'b0;
         busy_nx      = 1'b0;
         sda_oe_nx    = 1'b0;
         scl_hold_nx  = 1'b0;
      end else if (start_evt) begin
         state_nx     = ST_ADDR;
         bit_cnt_nx   = 3'd0;
         byte_done_nx = 1'b0;
         busy_nx      = 1'b0;
         sda_oe_nx    = 1'b0;
         scl_hold_nx  = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_WAIT_STOP: begin
               state_nx = state;
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shift_q_nx = shift_full[6:0];
                  bit_cnt_nx = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     byte_done_nx = 1'b1;
                     if (shift_full[7:1] == ADDRESS) begin
                        busy_nx = 1'b1;
                        rw_nx   = shift_full[0];
                     end
                  end
               end else if (scl_fall && byte_done) begin
                  byte_done_nx = 1'b0;
                  if (busy_q) begin
                     sda_oe_nx = 1'b1;
                     state_nx  = ST_ADDR_ACK;
                  end else begin
                     state_nx = ST_WAIT_STOP;
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_hold) begin
                  latch_tx = 1'b1;
               end else if (scl_rise) begin
                  tx_req_nx = rw_bit;
               end else if (scl_fall) begin
                  if (rw_bit) begin
                     latch_tx = 1'b1;
                  end else begin
                     sda_oe_nx  = 1'b0;
                     bit_cnt_nx = 3'd0;
                     state_nx   = ST_WRITE_BYTE;
                  end
               end
            end

            ST_WRITE_BYTE: begin
               if (scl_rise) begin
                  shift_q_nx = shift_full[6:0];
                  bit_cnt_nx = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data_nx   = shift_full;
                     rx_valid_nx  = 1'b1;
                     byte_done_nx = 1'b1;
                  end
               end else if (scl_fall && byte_done) begin
                  byte_done_nx = 1'b0;
                  sda_oe_nx    = 1'b1;
                  state_nx     = ST_WRITE_ACK;
               end
            end

            ST_WRITE_ACK: begin
               if (scl_fall) begin
                  sda_oe_nx  = 1'b0;
                  bit_cnt_nx = 3'd0;
                  state_nx   = ST_WRITE_BYTE;
               end
            end

            ST_READ_BYTE: begin
               // The cycle after a stretched latch only lets go of SCL.
               if (scl_hold) begin
                  scl_hold_nx = 1'b0;
               end else if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe_nx  = 1'b0;
                     bit_cnt_nx = 3'd0;
                     state_nx   = ST_READ_ACK;
                  end else begin
                     sda_oe_nx   = ~tx_shift[6];
                     tx_shift_nx = {tx_shift[5:0], 1'b0};
                     bit_cnt_nx  = bit_cnt + 3'd1;
                  end
               end
            end

            ST_READ_ACK: begin
               if (scl_hold) begin
                  latch_tx = 1'b1;
               end else if (scl_rise) begin
                  if (!sda_s) begin
                     tx_req_nx = 1'b1;
                  end else begin
                     state_nx = ST_WAIT_STOP;
                  end
               end else if (scl_fall) begin
                  latch_tx = 1'b1;
               end
            end

            default: begin
               state_nx = ST_IDLE;
            end
         endcase

         if (latch_tx) begin
            if (tx_ready) begin
               tx_shift_nx = tx_data[6:0];
               sda_oe_nx   = ~tx_data[7];
               bit_cnt_nx  = 3'd0;
               state_nx    = ST_READ_BYTE;
            end else begin
               scl_hold_nx = 1'b1;
            end
         end
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) controller. It is the responding end for the team's i2c_master on the same bus.
- Oversamples open-drain SCL/SDA in the sysclk domain (100 MHz; bus up to 400 kHz) and detects START, STOP and repeated START.
- Matches a fixed 7-bit address, ACKs, delivers written bytes to local logic and serves read bytes from local logic.
- Optionally stretches SCL while local read data is not ready.

Parameters:
- ADDRESS, 7'h42, 7-bit target address this block responds to.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (minimum 2).

Ports:
- sysclk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- scl_i  input  1  SCL pad level.
- sda_i  input  1  SDA pad level.
- scl_oe  output  1  1 = pull SCL low (stretch). Open-drain; never drives high.
- sda_oe  output  1  1 = pull SDA low. Open-drain; never drives high.
- rx_data  output  8  last byte written by the master; held until the next byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_data  input  8  next byte to return on a read.
- tx_valid  input  1  tx_data is ready (used only with CLOCK_STRETCH_EN).
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- busy  output  1  1 from address match until STOP or repeated START.

Behaviour:
- Reset (reset_n low, any time, async): all outputs 0, rx_data = 0, state Idle, bit counter 0, synchronizers preset to 1 (idle bus). The bus is released immediately.
- Synchronizer: pins pass through SYNC_STAGES flops, then one history flop for edge detection. Pin-to-event latency is SYNC_STAGES+1 sysclk cycles.
- Events, evaluated in priority order in the same cycle:
  - STOP: sync SDA rises while sync SCL = 1.
  - START: sync SDA falls while sync SCL = 1.
  - SCL rise.
  - SCL fall.
- STOP in any state: go to Idle, sda_oe = 0, scl_oe = 0, busy = 0.
- START in any state, including repeated START: go to Addr, bit counter 0, sda_oe = 0, busy = 0.
- Sampling and driving rules:
  - Data bits are sampled on SCL rise, MSB first.
  - sda_oe changes only on the cycle an SCL fall is detected, or on STOP/START.
- States and transitions:
  - Idle: wait for START.
  - Addr: shift 8 bits (7 address + R/W).
    - On the 8th SCL rise, if address[7:1] == ADDRESS, set busy = 1 and latch R/W.
    - On the following SCL fall: assert sda_oe if matched, else go to Wait_Stop.
  - Addr_Ack: on SCL rise, if R/W = 1, pulse tx_req.
    - On SCL fall, if R/W = 0: release SDA and go to Write_Byte.
    - On SCL fall, if R/W = 1: latch tx_data, set sda_oe = ~tx_data[7], go to Read_Byte.
  - Write_Byte: shift 8 bits.
    - On the 8th SCL rise: update rx_data and pulse rx_valid.
    - On the next SCL fall: assert sda_oe (always ACK) and go to Write_Ack.
  - Write_Ack: on SCL fall, release SDA, reset bit counter, go to Write_Byte.
  - Read_Byte: on each SCL fall, shift and set sda_oe = ~next bit.
    - After the fall that ends bit 0: sda_oe = 0, go to Read_Ack.
  - Read_Ack: sample SDA on SCL rise.
    - SDA = 0 (master ACK): pulse tx_req; on the next SCL fall latch tx_data, drive its MSB, go to Read_Byte.
    - SDA = 1 (NACK): go to Wait_Stop with SDA released.
  - Wait_Stop: ignore SCL edges; exit only on STOP or START.
- Boundary rules:
  - The bit counter is 3 bits and wraps at 8 → 0 per byte.
  - The general-call address (0x00) is not matched unless ADDRESS = 0.
  - A START during an in-progress ACK releases SDA in the same cycle it is detected.

Optional Feature:
- Macro: CLOCK_STRETCH_EN.
- Defined:
  - At any SCL fall where tx_data is to be latched, if tx_valid = 0: set scl_oe = 1 and keep the state.
  - The first cycle tx_valid = 1: latch tx_data and drive MSB onto sda_oe.
  - The following cycle: scl_oe = 0.
  - STOP, START or reset clears scl_oe.
- Undefined:
  - scl_oe is tied to 0.
  - tx_valid is ignored.
  - tx_data is latched unconditionally at that fall.

Test Plan:
- Write 0x84 (addr 0x42, W), then 0xA5, 0x3C, then STOP → ACK low on both ACK slots of data bytes and the address; rx_valid pulses twice with rx_data 0xA5 then 0x3C; busy falls after STOP.
- Address 0x43 W, 0xFF → sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Read addr 0x42 R with tx_data 0x5A, master ACK, tx_data 0xC3, master NACK, STOP → SDA bits 01011010 then 11000011; tx_req pulses 2×; SDA released after NACK.
- Repeated START mid-write (after 4 data bits), then addr 0x42 R → no rx_valid for the partial byte; read of tx_data proceeds correctly.
- reset_n low during a read while driving a 0 bit → sda_oe = 0 asynchronously; state Idle after release; next START/addr transaction works.
- With CLOCK_STRETCH_EN and tx_valid = 0 for 1000 cycles at the read latch → scl_oe = 1 for that interval; released 2 cycles after tx_valid rises; correct byte returned.
